// File: rtl/data_bus_arbiter_if.sv
// Bundle of the two master request ports and the shared slave bus.
// slave  : the arbiter's view (takes requests and read data, drives acks and the bus).
// master : the environment's view (drives requests and slave read data).
interface data_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // master 0 (CPU load/store path)
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [2:0]        m0_strb;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_ack;

    // master 1 (debug / program loader)
    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [2:0]        m1_strb;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_ack;

    // shared slave bus
    logic              busEn;
    logic              busWe;
    logic [ADDR_W-1:0] busAddr;
    logic [DATA_W-1:0] busWData;
    logic [2:0]        busStrb;
    logic [DATA_W-1:0] busRData;
    logic              grant;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_strb,
        output m0_rdata, m0_ack,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_strb,
        output m1_rdata, m1_ack,
        output busEn, busWe, busAddr, busWData, busStrb, grant,
        input  busRData
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_strb,
        input  m0_rdata, m0_ack,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_strb,
        input  m1_rdata, m1_ack,
        input  busEn, busWe, busAddr, busWData, busStrb, grant,
        output busRData
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter for the shared data-RAM/peripheral bus.
// One transaction at a time: IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> RESP (one-cycle ack).
// Every output is a flop; the bus-side output registers double as the payload latched at grant.
module data_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1     // legal range 0..15
) (
    input  logic              clk,
    input  logic              reset,  // synchronous, active-low
    data_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    // control state
    state_t            state_r;
    logic              owner_r;
    logic              last_grant_r;
    logic [3:0]        wait_cnt_r;

    // registered outputs; bus_* hold the latched payload for the whole ACCESS phase
    logic              bus_en_r;
    logic              bus_we_r;
    logic [ADDR_W-1:0] bus_addr_r;
    logic [DATA_W-1:0] bus_wdata_r;
    logic [2:0]        bus_strb_r;
    logic              grant_r;
    logic              m0_ack_r;
    logic              m1_ack_r;
    logic [DATA_W-1:0] m0_rdata_r;   // per-master copy of the captured read data
    logic [DATA_W-1:0] m1_rdata_r;

    // arbitration result and the winner's payload
    logic              any_req_s;
    logic              winner_s;
    logic              win_we_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;
    logic [2:0]        win_strb_s;

    // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last.
    always_comb begin
        any_req_s = bus.m0_req | bus.m1_req;
        if (bus.m0_req && bus.m1_req) begin
            winner_s = ~last_grant_r;
        end else if (bus.m1_req) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end

        if (winner_s) begin
            win_we_s    = bus.m1_we;
            win_addr_s  = bus.m1_addr;
            win_wdata_s = bus.m1_wdata;
            win_strb_s  = bus.m1_strb;
        end else begin
            win_we_s    = bus.m0_we;
            win_addr_s  = bus.m0_addr;
            win_wdata_s = bus.m0_wdata;
            win_strb_s  = bus.m0_strb;
        end
    end

    // Transaction FSM with all outputs registered alongside the state transitions.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;           // makes m0 win the first tie
            wait_cnt_r   <= 4'd0;
            bus_en_r     <= 1'b0;
            bus_we_r     <= 1'b0;
            bus_addr_r   <= {ADDR_W{1'b0}};
            bus_wdata_r  <= {DATA_W{1'b0}};
            bus_strb_r   <= 3'd0;
            grant_r      <= 1'b0;
            m0_ack_r     <= 1'b0;
            m1_ack_r     <= 1'b0;
            m0_rdata_r   <= {DATA_W{1'b0}};
            m1_rdata_r   <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    m0_ack_r   <= 1'b0;
                    m1_ack_r   <= 1'b0;
                    m0_rdata_r <= {DATA_W{1'b0}};
                    m1_rdata_r <= {DATA_W{1'b0}};
                    if (any_req_s) begin
                        // Payload is captured here; later req/payload changes are ignored.
                        state_r      <= ST_ACCESS;
                        owner_r      <= winner_s;
                        last_grant_r <= winner_s;
                        wait_cnt_r   <= WAIT_INIT;
                        grant_r      <= winner_s;
                        bus_en_r     <= 1'b1;
                        bus_we_r     <= win_we_s;
                        bus_addr_r   <= win_addr_s;
                        bus_wdata_r  <= win_wdata_s;
                        bus_strb_r   <= win_strb_s;
                    end else begin
                        state_r      <= ST_IDLE;
                        grant_r      <= 1'b0;
                        bus_en_r     <= 1'b0;
                        bus_we_r     <= 1'b0;
                    end
                end

                ST_ACCESS: begin
                    if (wait_cnt_r != 4'd0) begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end else begin
                        // Last access cycle: slave read data is valid now.
                        state_r     <= ST_RESP;
                        bus_en_r    <= 1'b0;
                        bus_we_r    <= 1'b0;
                        bus_addr_r  <= {ADDR_W{1'b0}};
                        bus_wdata_r <= {DATA_W{1'b0}};
                        bus_strb_r  <= 3'd0;
                        if (owner_r) begin
                            m1_ack_r   <= 1'b1;
                            m1_rdata_r <= bus_we_r ? {DATA_W{1'b0}} : bus.busRData;
                        end else begin
                            m0_ack_r   <= 1'b1;
                            m0_rdata_r <= bus_we_r ? {DATA_W{1'b0}} : bus.busRData;
                        end
                    end
                end

                ST_RESP: begin
                    // One-cycle ack is over; always return to IDLE for at least one cycle.
                    state_r    <= ST_IDLE;
                    grant_r    <= 1'b0;
                    m0_ack_r   <= 1'b0;
                    m1_ack_r   <= 1'b0;
                    m0_rdata_r <= {DATA_W{1'b0}};
                    m1_rdata_r <= {DATA_W{1'b0}};
                end

                default: begin
                    state_r     <= ST_IDLE;
                    wait_cnt_r  <= 4'd0;
                    grant_r     <= 1'b0;
                    bus_en_r    <= 1'b0;
                    bus_we_r    <= 1'b0;
                    bus_addr_r  <= {ADDR_W{1'b0}};
                    bus_wdata_r <= {DATA_W{1'b0}};
                    bus_strb_r  <= 3'd0;
                    m0_ack_r    <= 1'b0;
                    m1_ack_r    <= 1'b0;
                    m0_rdata_r  <= {DATA_W{1'b0}};
                    m1_rdata_r  <= {DATA_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.busEn    = bus_en_r;
    assign bus.busWe    = bus_we_r;
    assign bus.busAddr  = bus_addr_r;
    assign bus.busWData = bus_wdata_r;
    assign bus.busStrb  = bus_strb_r;
    assign bus.grant    = grant_r;
    assign bus.m0_ack   = m0_ack_r;
    assign bus.m1_ack   = m1_ack_r;
    assign bus.m0_rdata = m0_rdata_r;
    assign bus.m1_rdata = m1_rdata_r;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Randomized bench for data_bus_arbiter with a transaction-schedule reference model.
// At each granted request the model writes the whole expected future (bus cycles, ack
// cycle, read data) into per-edge expectation tables; each edge's outputs are compared.
module tb_data_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WAIT   = 1;
    localparam int NRAND  = 1500;
    localparam int DEPTH  = NRAND + 300;

    logic clk = 1'b0;
    logic reset;

    // Free-running clock.
    always #5 clk = ~clk;

    data_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    data_bus_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // expected outputs after each rising edge (index = edge number)
    logic        exp_en    [DEPTH];
    logic        exp_we    [DEPTH];
    logic [31:0] exp_addr  [DEPTH];
    logic [31:0] exp_wdata [DEPTH];
    logic [2:0]  exp_strb  [DEPTH];
    logic        exp_grant [DEPTH];
    logic        exp_ack0  [DEPTH];
    logic        exp_ack1  [DEPTH];
    logic [31:0] exp_rd0   [DEPTH];
    logic [31:0] exp_rd1   [DEPTH];
    logic [31:0] rd_tab    [DEPTH];   // slave read data presented at each edge

    int   edge_no;
    int   free_edge;    // first edge at which a new grant can happen
    logic last_win;
    int   n_checks;
    int   n_pass;

    // stimulus for the next edge
    logic        s_rst;
    logic        s_r0, s_we0, s_r1, s_we1;
    logic [31:0] s_a0, s_d0, s_a1, s_d1;
    logic [2:0]  s_s0, s_s1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s edge %0d: got %h expected %h", tag, edge_no, got, want);
        end
    endtask

    task automatic clear_exp(input int e);
        exp_en[e]    = 1'b0;
        exp_we[e]    = 1'b0;
        exp_addr[e]  = 32'd0;
        exp_wdata[e] = 32'd0;
        exp_strb[e]  = 3'd0;
        exp_grant[e] = 1'b0;
        exp_ack0[e]  = 1'b0;
        exp_ack1[e]  = 1'b0;
        exp_rd0[e]   = 32'd0;
        exp_rd1[e]   = 32'd0;
    endtask

    // Reference model: decide what this edge does and schedule the resulting transaction.
    task automatic model_step();
        logic        w;
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  s;
        int          r;
        if (!s_rst) begin
            for (int i = edge_no; i < edge_no + WAIT + 4; i++) clear_exp(i);
            last_win  = 1'b1;
            free_edge = edge_no + 1;
        end else if (edge_no >= free_edge && (s_r0 || s_r1)) begin
            w  = (s_r0 && s_r1) ? ~last_win : s_r1;
            last_win = w;
            we = w ? s_we1 : s_we0;
            a  = w ? s_a1  : s_a0;
            d  = w ? s_d1  : s_d0;
            s  = w ? s_s1  : s_s0;
            for (int i = 0; i <= WAIT; i++) begin
                exp_en[edge_no + i]    = 1'b1;
                exp_we[edge_no + i]    = we;
                exp_addr[edge_no + i]  = a;
                exp_wdata[edge_no + i] = d;
                exp_strb[edge_no + i]  = s;
                exp_grant[edge_no + i] = w;
            end
            r = edge_no + WAIT + 1;
            exp_grant[r] = w;
            if (w) begin
                exp_ack1[r] = 1'b1;
                exp_rd1[r]  = we ? 32'd0 : rd_tab[r];
            end else begin
                exp_ack0[r] = 1'b1;
                exp_rd0[r]  = we ? 32'd0 : rd_tab[r];
            end
            free_edge = edge_no + WAIT + 3;
        end
    endtask

    // Drive the stimulus, update the model, clock once and compare every output.
    task automatic run_edge();
        reset           = s_rst;
        bus_if.m0_req   = s_r0;
        bus_if.m0_we    = s_we0;
        bus_if.m0_addr  = s_a0;
        bus_if.m0_wdata = s_d0;
        bus_if.m0_strb  = s_s0;
        bus_if.m1_req   = s_r1;
        bus_if.m1_we    = s_we1;
        bus_if.m1_addr  = s_a1;
        bus_if.m1_wdata = s_d1;
        bus_if.m1_strb  = s_s1;
        bus_if.busRData = rd_tab[edge_no];
        model_step();
        @(posedge clk);
        #1;
        check_val("busEn",  32'(bus_if.busEn),  32'(exp_en[edge_no]));
        check_val("busWe",  32'(bus_if.busWe),  32'(exp_we[edge_no]));
        check_val("grant",  32'(bus_if.grant),  32'(exp_grant[edge_no]));
        check_val("m0_ack", 32'(bus_if.m0_ack), 32'(exp_ack0[edge_no]));
        check_val("m1_ack", 32'(bus_if.m1_ack), 32'(exp_ack1[edge_no]));
        check_val("m0_rdata", bus_if.m0_rdata, exp_rd0[edge_no]);
        check_val("m1_rdata", bus_if.m1_rdata, exp_rd1[edge_no]);
        if (exp_en[edge_no]) begin
            check_val("busAddr",  bus_if.busAddr,  exp_addr[edge_no]);
            check_val("busWData", bus_if.busWData, exp_wdata[edge_no]);
            check_val("busStrb",  32'(bus_if.busStrb), 32'(exp_strb[edge_no]));
        end
        edge_no++;
    endtask

    task automatic idle_reqs();
        s_r0 = 1'b0;
        s_r1 = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        edge_no   = 0;
        free_edge = 1;
        last_win  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            clear_exp(i);
            rd_tab[i] = (i < 60) ? 32'hDEADBEEF : $urandom;
        end
        s_rst = 1'b0;
        s_r0 = 1'b0; s_we0 = 1'b0; s_a0 = 32'd0; s_d0 = 32'd0; s_s0 = 3'd0;
        s_r1 = 1'b0; s_we1 = 1'b0; s_a1 = 32'd0; s_d1 = 32'd0; s_s1 = 3'd0;

        // reset held 3 edges with both masters requesting
        s_r0 = 1'b1; s_r1 = 1'b1;
        repeat (3) run_edge();
        s_rst = 1'b1;
        idle_reqs();
        run_edge();

        // m0 load at 0x100; address changes to 0x200 after the grant
        s_r0 = 1'b1; s_we0 = 1'b0; s_a0 = 32'h100; s_s0 = 3'b010;
        for (int i = 0; i < 8; i++) begin
            run_edge();
            s_a0 = 32'h200;
            if (exp_ack0[edge_no - 1]) break;
        end
        idle_reqs();
        run_edge();

        // m1 store
        s_r1 = 1'b1; s_we1 = 1'b1; s_a1 = 32'h20; s_d1 = 32'h12345678; s_s1 = 3'b010;
        for (int i = 0; i < 8; i++) begin
            run_edge();
            if (exp_ack1[edge_no - 1]) break;
        end
        idle_reqs();
        run_edge();

        // both requesting continuously: grants alternate
        s_r0 = 1'b1; s_we0 = 1'b0; s_a0 = 32'h400;
        s_r1 = 1'b1; s_we1 = 1'b0; s_a1 = 32'h800;
        repeat (18) run_edge();
        idle_reqs();
        repeat (4) run_edge();

        // reset pulse in the middle of an access, then a fresh m1 request
        s_r0 = 1'b1; s_we0 = 1'b1; s_a0 = 32'h44; s_d0 = 32'hCAFE0001;
        repeat (2) run_edge();
        s_rst = 1'b0;
        run_edge();
        s_rst = 1'b1;
        s_r0 = 1'b0;
        s_r1 = 1'b1; s_we1 = 1'b0; s_a1 = 32'h88;
        for (int i = 0; i < 8; i++) begin
            run_edge();
            if (exp_ack1[edge_no - 1]) break;
        end
        idle_reqs();
        run_edge();

        // randomized traffic with occasional reset pulses
        for (int n = 0; n < NRAND; n++) begin
            s_rst = ($urandom_range(149, 0) != 0);
            if (s_r0 && exp_ack0[edge_no - 1]) begin
                s_r0 = ($urandom_range(1, 0) == 1);
                s_we0 = $urandom_range(1, 0) == 1; s_a0 = $urandom; s_d0 = $urandom; s_s0 = 3'($urandom);
            end else if (!s_r0) begin
                s_r0 = ($urandom_range(2, 0) == 0);
                s_we0 = $urandom_range(1, 0) == 1; s_a0 = $urandom; s_d0 = $urandom; s_s0 = 3'($urandom);
            end else if ($urandom_range(9, 0) == 0) begin
                s_a0 = $urandom; s_d0 = $urandom; s_we0 = ~s_we0;
            end else if ($urandom_range(39, 0) == 0) begin
                s_r0 = 1'b0;
            end else begin
                s_r0 = 1'b1;
            end
            if (s_r1 && exp_ack1[edge_no - 1]) begin
                s_r1 = ($urandom_range(1, 0) == 1);
                s_we1 = $urandom_range(1, 0) == 1; s_a1 = $urandom; s_d1 = $urandom; s_s1 = 3'($urandom);
            end else if (!s_r1) begin
                s_r1 = ($urandom_range(2, 0) == 0);
                s_we1 = $urandom_range(1, 0) == 1; s_a1 = $urandom; s_d1 = $urandom; s_s1 = 3'($urandom);
            end else if ($urandom_range(9, 0) == 0) begin
                s_a1 = $urandom; s_d1 = $urandom; s_strb_flip();
            end else if ($urandom_range(39, 0) == 0) begin
                s_r1 = 1'b0;
            end else begin
                s_r1 = 1'b1;
            end
            run_edge();
        end

        // drain
        s_rst = 1'b1;
        idle_reqs();
        repeat (6) run_edge();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    task automatic s_strb_flip();
        s_s1 = s_s1 + 3'd1;
    endtask

endmodule
